// File: rtl/led_blink_array.sv
// Multi-channel LED driver: one shared half-period timebase, with a per-channel
// mode of off/on/lockstep blink/counted burst. Bursts report completion with a done pulse.
module led_blink_array #(
  parameter int   NUM_CH      = 4,
  parameter int   CNT_W       = 26,
  parameter int   HALF_PERIOD = 50000000,
  parameter logic LED_ACTIVE  = 1'b0,
  parameter int   BURST_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2*NUM_CH-1:0]   i_mode,
  input  logic [NUM_CH-1:0]     i_start,
  input  logic [BURST_W-1:0]    i_burst_cnt,
  input  logic                  i_phase_sync,
  output logic [NUM_CH-1:0]     o_led,
  output logic [NUM_CH-1:0]     o_busy,
  output logic [NUM_CH-1:0]     o_burst_done
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_ON, S_OFF} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic               tick, adv;
  state_e             state_q [NUM_CH];
  state_e             state_d [NUM_CH];
  logic [BURST_W-1:0] rem_q   [NUM_CH];
  logic [BURST_W-1:0] rem_d   [NUM_CH];
  logic [1:0]         mode    [NUM_CH];
  logic [NUM_CH-1:0]  led_q, led_d;
  logic [NUM_CH-1:0]  done_q, done_d;

  assign tick = (cnt_q == CNT_LAST);
  // Phase sync wins over a coinciding tick, so no burst step happens in that cycle.
  assign adv  = tick & ~i_phase_sync;

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (i_phase_sync) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      mode[i] = i_mode[2*i +: 2];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
      done_d[i]  = 1'b0;
      led_d[i]   = ~LED_ACTIVE;
      o_busy[i]  = (state_q[i] != S_IDLE);

      case (mode[i])
        2'b01:   led_d[i] = LED_ACTIVE;
        2'b10:   if (phase_q) led_d[i] = LED_ACTIVE;
        2'b11:   if (state_q[i] == S_ON) led_d[i] = LED_ACTIVE;
        default: led_d[i] = ~LED_ACTIVE;
      endcase

      if (mode[i] != 2'b11) begin
        state_d[i] = S_IDLE;
      end else begin
        case (state_q[i])
          S_IDLE: begin
            if (i_start[i] && (i_burst_cnt != '0)) begin
              state_d[i] = S_ARM;
              rem_d[i]   = i_burst_cnt;
            end
          end
          S_ARM: if (adv) state_d[i] = S_ON;
          S_ON: begin
            if (adv) begin
              state_d[i] = S_OFF;
              rem_d[i]   = rem_q[i] - BURST_W'(1);
            end
          end
          S_OFF: begin
            if (adv) begin
              if (rem_q[i] == '0) begin
                state_d[i] = S_IDLE;
                done_d[i]  = 1'b1;
              end else begin
                state_d[i] = S_ON;
              end
            end
          end
          default: state_d[i] = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      led_q   <= {NUM_CH{~LED_ACTIVE}};
      done_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        rem_q[i]   <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      led_q   <= led_d;
      done_q  <= done_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
      end
    end
  end

  assign o_led        = led_q;
  assign o_burst_done = done_q;

endmodule

// File: tb/tb_led_blink_array.sv
// Scoreboard bench for led_blink_array: a step-counting reference model queues the
// expected pins each cycle, and the DUT pins are popped and compared one cycle later.
module tb_led_blink_array;

  localparam int HP = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] i_mode;
  logic [3:0] i_start;
  logic [3:0] i_burst_cnt;
  logic       i_phase_sync;
  logic [3:0] o_led, o_busy, o_burst_done;

  led_blink_array #(
    .NUM_CH(4), .CNT_W(26), .HALF_PERIOD(HP), .LED_ACTIVE(1'b0), .BURST_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_mode(i_mode), .i_start(i_start),
    .i_burst_cnt(i_burst_cnt), .i_phase_sync(i_phase_sync),
    .o_led(o_led), .o_busy(o_busy), .o_burst_done(o_burst_done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: step -1 idle, 0 armed, odd steps lit, even steps dark, 2K final dark.
  int   m_cnt, m_phase;
  int   m_step [4];
  int   m_k    [4];
  logic [11:0] sbq [$];

  int   flashes, track;
  int   done_cnt [4];
  logic prev_led0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] nled, ndone, nbusy;
    logic [1:0] md;
    logic       lit, tick, etick;
    nled = 4'hF; ndone = 4'h0; nbusy = 4'h0;
    if (!reset_n) begin
      m_cnt = 0; m_phase = 0;
      for (int c = 0; c < 4; c++) begin m_step[c] = -1; m_k[c] = 0; end
    end else begin
      tick  = (m_cnt == HP - 1);
      etick = tick && !i_phase_sync;
      for (int c = 0; c < 4; c++) begin
        md = i_mode[2*c +: 2];
        case (md)
          2'd1:    lit = 1'b1;
          2'd2:    lit = (m_phase == 1);
          2'd3:    lit = (m_step[c] > 0) && (m_step[c] % 2 == 1);
          default: lit = 1'b0;
        endcase
        nled[c] = ~lit;
        if (md != 2'd3) begin
          m_step[c] = -1;
        end else if (m_step[c] < 0) begin
          if (i_start[c] && i_burst_cnt != 0) begin
            m_step[c] = 0;
            m_k[c]    = int'(i_burst_cnt);
          end
        end else if (etick) begin
          if (m_step[c] == 2 * m_k[c]) begin
            m_step[c] = -1;
            ndone[c]  = 1'b1;
          end else begin
            m_step[c]++;
          end
        end
      end
      if (i_phase_sync) begin
        m_cnt = 0; m_phase = 0;
      end else if (tick) begin
        m_cnt = 0; m_phase = 1 - m_phase;
      end else begin
        m_cnt++;
      end
    end
    for (int c = 0; c < 4; c++) nbusy[c] = (m_step[c] >= 0);
    sbq.push_back({nled, nbusy, ndone});
  endtask

  task automatic cycle();
    logic [11:0] e;
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (sbq.size() == 0) begin
      chk("sbq_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("led",  {28'd0, o_led},        {28'd0, e[11:8]});
      chk("busy", {28'd0, o_busy},       {28'd0, e[7:4]});
      chk("done", {28'd0, o_burst_done}, {28'd0, e[3:0]});
    end
    if (track != 0 && prev_led0 === 1'b1 && o_led[0] === 1'b0) flashes++;
    prev_led0 = o_led[0];
    for (int c = 0; c < 4; c++) if (o_burst_done[c] === 1'b1) done_cnt[c]++;
  endtask

  task automatic run(input int n);
    for (int j = 0; j < n; j++) cycle();
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    run(n);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) done_cnt[c] = 0;
  endtask

  task automatic pulse_start(input logic [3:0] s, input logic [3:0] k);
    i_start = s; i_burst_cnt = k;
    run(1);
    i_start = 4'h0;
  endtask

  initial begin
    reset_n = 1'b0; i_mode = 8'h00; i_start = 4'h0;
    i_burst_cnt = 4'h0; i_phase_sync = 1'b0;
    flashes = 0; track = 0; prev_led0 = 1'b1;

    // Reset state
    do_reset(3);
    chk("rst_led",  {28'd0, o_led},        32'hF);
    chk("rst_busy", {28'd0, o_busy},       32'h0);
    chk("rst_done", {28'd0, o_burst_done}, 32'h0);

    // Static modes: ch0 on, ch1 off, then ch0 off
    i_mode = 8'b0000_0001;
    run(1);
    chk("static_on",  {31'd0, o_led[0]}, 32'd0);
    chk("static_off", {31'd0, o_led[1]}, 32'd1);
    run(2);
    i_mode = 8'b0000_0000;
    run(1);
    chk("static_back", {31'd0, o_led[0]}, 32'd1);

    // Continuous blink on ch2/ch3, phase sync in a lit half
    do_reset(2);
    i_mode = 8'b1010_0000;
    run(4);
    chk("blink_dark", {30'd0, o_led[3:2]}, 32'd3);
    run(2);
    chk("blink_lit", {30'd0, o_led[3:2]}, 32'd0);
    run(13);
    i_phase_sync = 1'b1;
    run(1);
    i_phase_sync = 1'b0;
    run(12);

    // Burst K=3 on ch0, with an ignored start mid-burst
    do_reset(2);
    i_mode = 8'b0000_0011;
    run(1);
    flashes = 0; track = 1; prev_led0 = o_led[0];
    pulse_start(4'b0001, 4'd3);
    chk("busy_rise", {31'd0, o_busy[0]}, 32'd1);
    run(10);
    pulse_start(4'b0001, 4'd5);
    run(30);
    track = 0;
    chk("burst_flashes", flashes, 32'd3);
    chk("burst_dones", done_cnt[0], 32'd1);

    // Ignored starts: zero count, and a channel not in burst mode
    pulse_start(4'b0001, 4'd0);
    run(2);
    chk("start_zero", {31'd0, o_busy[0]}, 32'd0);
    i_mode = 8'b0000_0010;
    pulse_start(4'b0001, 4'd3);
    run(2);
    chk("start_blink", {31'd0, o_busy[0]}, 32'd0);

    // Abort ch1 while lit, then a fresh burst
    do_reset(2);
    i_mode = 8'b0000_1100;
    pulse_start(4'b0010, 4'd2);
    for (int j = 0; j < 20 && m_step[1] != 1; j++) run(1);
    run(1);
    chk("abort_pre", {31'd0, o_led[1]}, 32'd0);
    i_mode = 8'b0000_0000;
    run(1);
    chk("abort_led",  {31'd0, o_led[1]},  32'd1);
    chk("abort_busy", {31'd0, o_busy[1]}, 32'd0);
    i_mode = 8'b0000_1100;
    run(1);
    pulse_start(4'b0010, 4'd1);
    run(16);
    chk("abort_dones", done_cnt[1], 32'd1);

    // Reset mid-burst on all channels, started together
    do_reset(1);
    i_mode = 8'b1111_1111;
    pulse_start(4'b1111, 4'd3);
    run(10);
    chk("multi_busy", {28'd0, o_busy}, 32'hF);
    reset_n = 1'b0;
    run(1);
    reset_n = 1'b1;
    chk("midrst_busy", {28'd0, o_busy}, 32'h0);
    chk("midrst_done", {28'd0, o_burst_done}, 32'h0);
    run(4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/led_blink_array.md
# led_blink_array

Multi-channel LED driver for the traffic-light board, generalising the single-lamp blinker to `NUM_CH` independently moded outputs. It shares one half-period timebase across all channels. Each channel can be forced off, held on, blink continuously in lockstep with the other channels, or emit a counted burst of flashes with a completion pulse. It sits between the traffic-light sequencer (mode/start control) and the board LED pins.

## Interface
Parameters:
- `NUM_CH`, 4, number of LED channels.
- `CNT_W`, 26, timebase counter width; requires `HALF_PERIOD <= 2**CNT_W`.
- `HALF_PERIOD`, 50000000, clk cycles per on or off half-period; minimum 2.
- `LED_ACTIVE`, 1'b0, pin level that lights an LED; unlit level is `~LED_ACTIVE`.
- `BURST_W`, 4, width of the burst flash count.

Ports:
- `clk`, in, 1: clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `i_mode`, in, 2*NUM_CH: per-channel mode; bits [2i+1:2i] belong to channel i. 00 = off, 01 = on, 10 = continuous blink, 11 = burst.
- `i_start`, in, NUM_CH: per-channel burst start; sampled every cycle.
- `i_burst_cnt`, in, BURST_W: flash count loaded on an accepted start (shared by all channels).
- `i_phase_sync`, in, 1: restarts the shared timebase and blink phase.
- `o_led`, out, NUM_CH: LED pin drive, registered.
- `o_busy`, out, NUM_CH: channel burst engine not IDLE; decoded directly from state.
- `o_burst_done`, out, NUM_CH: one-cycle pulse when a burst completes, registered.

## Operation
- **Timebase.**
  - `cnt` counts 0..HALF_PERIOD-1 and wraps.
  - `tick` = (`cnt` == HALF_PERIOD-1).
  - `phase` toggles on every tick.
  - `i_phase_sync` clears `cnt` and `phase` to 0. It takes priority over tick: a coinciding tick does not toggle `phase` and does not advance any burst state.
- **Lit decode per channel.**
  - off → unlit.
  - on → lit.
  - blink → lit when `phase` = 1; all blink channels are in lockstep.
  - burst → lit only in state ON.
- **Burst FSM per channel.** States are IDLE, ARM, ON, OFF.
  - IDLE → ARM on `i_start[i]` with mode 11 and `i_burst_cnt` ≠ 0. Loads `rem` = `i_burst_cnt`.
  - A start is ignored when `i_burst_cnt` = 0, when mode ≠ 11, or when the channel is not IDLE.
  - ARM → ON on tick. A start accepted in a tick cycle goes to ARM; that tick is not consumed.
  - ON → OFF on tick; `rem` decrements.
  - OFF → IDLE on tick when `rem` = 0, with `o_burst_done[i]` pulsed. Otherwise OFF → ON on tick.
  - Result: exactly `i_burst_cnt` flashes, each lasting HALF_PERIOD cycles lit and HALF_PERIOD cycles dark.
  - If mode leaves 11 while not IDLE, the channel returns to IDLE at the next edge with no done pulse.
- **Reset** (any time, including mid-burst):
  - `cnt` = 0, `phase` = 0, all channels IDLE, `rem` = 0.
  - `o_led` = all `~LED_ACTIVE`, `o_busy` = 0, `o_burst_done` = 0.
  - No done pulse is generated.

## Timing
- `o_led[i]` is registered from the current mode, `phase` and state, so it lags those by one clk.
- A mode change reaches the pin after one edge.
- After reset release, `phase` first toggles at the edge ending cycle HALF_PERIOD-1. Blink LEDs therefore light from cycle HALF_PERIOD+1 (one-cycle output lag).
- `o_busy` rises in the cycle after the accepted start.
- `o_burst_done` is high for exactly one cycle, the first cycle in IDLE. `o_busy` is 0 in that same cycle.
- Burst length from the accepted start to the done pulse is at most (2K+1)·HALF_PERIOD cycles for K flashes.
- Channels are independent; simultaneous starts on several channels stay tick-aligned.

## Test plan
Each scenario is independent; use HALF_PERIOD = 4, NUM_CH = 4, LED_ACTIVE = 0.
- **Reset.** Hold `reset_n` = 0 for 3 cycles → `o_led` = 4'b1111, `o_busy` = 0, `o_burst_done` = 0. Re-assert reset mid-burst → `o_busy[0]` = 0 at the next edge, no done pulse.
- **Static modes.** ch0 mode 01, ch1 mode 00 → `o_led[0]` = 0 one edge later, `o_led[1]` stays 1. Switch ch0 to 00 → `o_led[0]` = 1 one edge later.
- **Continuous blink.** ch2 and ch3 both mode 10 → identical waveforms: 4 cycles low, 4 cycles high, repeating, first low from cycle 5 after reset. Pulse `i_phase_sync` mid-low → both go high after one edge and restart a full 4-cycle dark half-period.
- **Burst K=3.** Set mode 11, pulse `i_start[0]` with `i_burst_cnt` = 3 → three 4-cycle lows separated by 4-cycle highs. `o_burst_done[0]` is high for one cycle after the third dark half-period; `o_busy[0]` spans start+1 through done-1.
- **Ignored starts.** `i_start` during a burst → flash count unchanged. `i_start` with `i_burst_cnt` = 0 → `o_busy` stays 0. `i_start` in mode 10 → `o_busy` stays 0.
- **Abort.** Change ch1 from mode 11 to 00 during ON → `o_led[1]` = 1 and `o_busy[1]` = 0 after one edge, no done pulse. A new start then behaves like a fresh burst.
